dmem_img_reader: RTL and testbench

- Reads a stored 28x28 8-bit grayscale image from the 256-bit data memory, one row per word.
- Serializes the image as a byte stream toward the SPART transmitter, using a valid/ready handshake.
- This is the read-side counterpart of the image capture FSM's DMEM write port. Captured frames are dumped to the host over serial for inspection and for building training data.
- Started by the CPU with a one-cycle pulse; reports completion with a one-cycle pulse.

---
 rtl/dmem_img_reader_if.sv | 27 ++
 rtl/dmem_img_reader.sv | 133 +++++++++++++
 tb/tb_dmem_img_reader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_img_reader_if.sv
// rtl/dmem_img_reader_if.sv - DMEM read port and byte stream toward the SPART transmitter
interface dmem_img_reader_if;
    logic         dmem_rden;
    logic [6:0]   dmem_rdaddr;
    logic [255:0] dmem_rddata;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (
        output dmem_rden,
        output dmem_rdaddr,
        input  dmem_rddata,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  dmem_rden,
        input  dmem_rdaddr,
        output dmem_rddata,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/dmem_img_reader.sv
// rtl/dmem_img_reader.sv - streams a stored grayscale image from DMEM out as bytes
module dmem_img_reader #(
    parameter logic [6:0] BASE_ADDR = 7'd0,
    parameter int         ROWS      = 28,
    parameter int         COLS      = 28,
    parameter int         RD_LAT    = 1,
    parameter bit         SEND_SYNC = 1'b1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    dmem_img_reader_if.master bus
);
    localparam int PW = COLS * 8;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, READ, WAIT, SEND, DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    lat_q, lat_d;
    logic [PW-1:0] shift_q, shift_d;

    logic          rden;
    logic [6:0]    rdaddr;
    logic [7:0]    tx_data;
    logic          tx_valid;

    // Only the packed pixel bytes of each word carry image data.
    if (PW < 256) begin : g_upper
        logic rddata_unused;
        assign rddata_unused = ^bus.dmem_rddata[255:PW];
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            lat_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lat_q   <= lat_d;
            shift_q <= shift_d;
        end
    end

    // Next-state and state-decoded outputs; outputs depend only on registers.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        lat_d    = lat_q;
        shift_d  = shift_q;
        busy     = 1'b0;
        done     = 1'b0;
        rden     = 1'b0;
        rdaddr   = '0;
        tx_data  = '0;
        tx_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = SEND_SYNC ? SYNC : READ;
                end
            end
            SYNC: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (bus.tx_ready) begin
                    state_d = READ;
                end
            end
            READ: begin
                busy    = 1'b1;
                rden    = 1'b1;
                rdaddr  = BASE_ADDR + 7'(row_q);
                lat_d   = 2'(RD_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (lat_q == 2'd0) begin
                    shift_d = bus.dmem_rddata[PW-1:0];
                    state_d = SEND;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = shift_q[7:0];
                if (bus.tx_ready) begin
                    shift_d = shift_q >> 8;
                    if (col_q == CW'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(ROWS - 1)) begin
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + RW'(1);
                            state_d = READ;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dmem_rden   = rden;
    assign bus.dmem_rdaddr = rdaddr;
    assign bus.tx_data     = tx_data;
    assign bus.tx_valid    = tx_valid;
endmodule

// File: tb/tb_dmem_img_reader.sv
// tb/tb_dmem_img_reader.sv - table-driven frame checks plus reset and start-filter sequences
module tb_dmem_img_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, busy_a, done_a;
    logic start_b, busy_b, done_b;

    dmem_img_reader_if if_a();
    dmem_img_reader_if if_b();

    dmem_img_reader u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_a),
        .busy  (busy_a),
        .done  (done_a),
        .bus   (if_a.master)
    );

    dmem_img_reader #(
        .BASE_ADDR (7'd100),
        .RD_LAT    (3),
        .SEND_SYNC (1'b0)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_b),
        .busy  (busy_b),
        .done  (done_b),
        .bus   (if_b.master)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    bit garb = 1'b0;
    bit sel  = 1'b0;

    function automatic logic [255:0] img_word(input int r, input bit g);
        logic [255:0] w;
        w = '0;
        for (int c = 0; c < 28; c++) w[8*c +: 8] = 8'((r * 28 + c) & 255);
        if (g) w[255:224] = '1;
        return w;
    endfunction

    function automatic logic [255:0] rnd_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    // DMEM models: data is valid only RD_LAT cycles after rden, noise otherwise.
    logic       b_p0v = 1'b0, b_p1v = 1'b0;
    logic [6:0] b_p0a = '0, b_p1a = '0;
    always @(posedge clk) begin
        if_a.dmem_rddata <= if_a.dmem_rden ? img_word(int'(if_a.dmem_rdaddr), garb) : rnd_word();
        b_p0v <= if_b.dmem_rden;
        b_p0a <= if_b.dmem_rdaddr;
        b_p1v <= b_p0v;
        b_p1a <= b_p0a;
        if_b.dmem_rddata <= b_p1v ? img_word(int'(b_p1a) - 100, garb) : rnd_word();
    end

    logic       m_busy, m_done, m_rden, m_valid;
    logic [6:0] m_addr;
    logic [7:0] m_data;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_rden  = sel ? if_b.dmem_rden : if_a.dmem_rden;
    assign m_addr  = sel ? if_b.dmem_rdaddr : if_a.dmem_rdaddr;
    assign m_valid = sel ? if_b.tx_valid : if_a.tx_valid;
    assign m_data  = sel ? if_b.tx_data : if_a.tx_data;

    task automatic drive(input logic st, input logic rdy);
        if (sel) begin
            start_b = st;
            if_b.tx_ready = rdy;
        end else begin
            start_a = st;
            if_a.tx_ready = rdy;
        end
    endtask

    int r_bytes, r_byte_err, r_rden, r_addr_err, r_stall_err, r_busy_err;
    int r_ndone, r_done_lat, r_first_valid, r_first_pix, r_tail_err, r_timeout;
    int r_gap_min, r_gap_max;

    task automatic run_frame(input bit s, input int pct, input bit g, input bit extra);
        int  base, cyc, last_hs, inv_run, tail;
        bit  sync, seen_valid, done_seen, prev_stall, hs;
        logic [7:0] prev_data, exp_byte;
        logic st, rdy;
        sel = s;
        garb = g;
        base = s ? 100 : 0;
        sync = !s;
        r_bytes = 0; r_byte_err = 0; r_rden = 0; r_addr_err = 0; r_stall_err = 0;
        r_busy_err = 0; r_ndone = 0; r_done_lat = -1; r_first_valid = -1;
        r_first_pix = -1; r_tail_err = 0; r_timeout = 0;
        r_gap_min = 1000; r_gap_max = -1;
        cyc = 0; last_hs = 0; inv_run = 0; tail = 0;
        seen_valid = 0; done_seen = 0; prev_stall = 0; prev_data = '0;
        @(negedge clk);
        drive(1'b1, 1'b1);
        while (1) begin
            @(negedge clk);
            cyc++;
            st  = extra && (cyc == 10 || cyc == 200 || m_done);
            rdy = (pct >= 100) ? 1'b1 : logic'($urandom_range(99) < pct);
            drive(st, rdy);
            hs = m_valid & rdy;
            if (!done_seen) begin
                if (m_busy != !m_done) r_busy_err++;
                if (m_rden) begin
                    if (m_addr != 7'(base + r_rden)) r_addr_err++;
                    r_rden++;
                end
                if (m_valid) begin
                    if (!seen_valid) begin
                        r_first_valid = cyc;
                        seen_valid = 1;
                    end else if (inv_run > 0) begin
                        if (inv_run < r_gap_min) r_gap_min = inv_run;
                        if (inv_run > r_gap_max) r_gap_max = inv_run;
                    end
                    inv_run = 0;
                end else if (seen_valid) begin
                    inv_run++;
                end
                if (prev_stall && (!m_valid || m_data != prev_data)) r_stall_err++;
                prev_stall = m_valid & !rdy;
                prev_data  = m_data;
                if (hs) begin
                    exp_byte = (sync && r_bytes == 0) ? 8'hA5 : 8'((r_bytes - int'(sync)) & 255);
                    if (m_data != exp_byte) r_byte_err++;
                    if (r_bytes == int'(sync)) r_first_pix = cyc;
                    r_bytes++;
                    last_hs = cyc;
                end
                if (m_done) begin
                    r_ndone++;
                    r_done_lat = cyc - last_hs;
                    done_seen = 1;
                end
            end else begin
                if (m_valid | m_rden | m_busy) r_tail_err++;
                if (m_done) r_ndone++;
                tail++;
                if (tail == 8) break;
            end
            if (cyc > 6000) begin
                r_timeout = 1;
                break;
            end
        end
        drive(1'b0, 1'b0);
    endtask

    typedef struct {
        bit s;
        int pct;
        bit g;
        bit extra;
        int exp_bytes;
        int exp_rden;
        int exp_first_valid;
        int exp_first_pix;
        int exp_gap;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int  nrd, spurious;
        bit  found;
        string p;

        vecs[0] = '{1'b0, 100, 1'b0, 1'b0, 785, 28, 1, 4, 2};
        vecs[1] = '{1'b0,  50, 1'b0, 1'b0, 785, 28, 1, 4, 2};
        vecs[2] = '{1'b0, 100, 1'b0, 1'b1, 785, 28, 1, 4, 2};
        vecs[3] = '{1'b0, 100, 1'b1, 1'b0, 785, 28, 1, 4, 2};
        vecs[4] = '{1'b1, 100, 1'b0, 1'b0, 784, 28, 5, 5, 4};
        vecs[5] = '{1'b1,  50, 1'b1, 1'b0, 784, 28, 5, 5, 4};

        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        if_a.tx_ready = 1'b0; if_b.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a_outputs", int'({busy_a, done_a, if_a.dmem_rden, if_a.dmem_rdaddr,
                                       if_a.tx_data, if_a.tx_valid}), 0);
        check("reset_b_outputs", int'({busy_b, done_b, if_b.dmem_rden, if_b.dmem_rdaddr,
                                       if_b.tx_data, if_b.tx_valid}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].s, vecs[i].pct, vecs[i].g, vecs[i].extra);
            p = $sformatf("v%0d_", i);
            check({p, "timeout"}, r_timeout, 0);
            check({p, "byte_count"}, r_bytes, vecs[i].exp_bytes);
            check({p, "byte_values"}, r_byte_err, 0);
            check({p, "rden_count"}, r_rden, vecs[i].exp_rden);
            check({p, "rdaddr_seq"}, r_addr_err, 0);
            check({p, "stall_hold"}, r_stall_err, 0);
            check({p, "busy"}, r_busy_err, 0);
            check({p, "done_count"}, r_ndone, 1);
            check({p, "done_latency"}, r_done_lat, 1);
            check({p, "first_valid_cycle"}, r_first_valid, vecs[i].exp_first_valid);
            check({p, "row_gap_min"}, r_gap_min, vecs[i].exp_gap);
            check({p, "row_gap_max"}, r_gap_max, vecs[i].exp_gap);
            check({p, "quiet_after_done"}, r_tail_err, 0);
            if (vecs[i].pct >= 100) check({p, "first_pixel_cycle"}, r_first_pix, vecs[i].exp_first_pix);
        end

        // Asynchronous reset while row 13 is being sent.
        sel = 1'b0;
        garb = 1'b0;
        nrd = 0;
        found = 0;
        @(negedge clk);
        drive(1'b1, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1);
            if (m_rden) nrd++;
            if (nrd == 14 && m_valid) begin
                found = 1;
                break;
            end
        end
        check("rst_reached_row13", int'(found), 1);
        check("rst_row13_pixel0", int'(if_a.tx_data), (13 * 28) & 255);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", int'({busy_a, done_a, if_a.dmem_rden, if_a.dmem_rdaddr,
                                         if_a.tx_data, if_a.tx_valid}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_a | busy_a | if_a.tx_valid | if_a.dmem_rden) spurious++;
        end
        check("rst_idle_after_release", spurious, 0);
        run_frame(1'b0, 100, 1'b0, 1'b0);
        check("rst_refr_timeout", r_timeout, 0);
        check("rst_refr_byte_count", r_bytes, 785);
        check("rst_refr_byte_values", r_byte_err, 0);
        check("rst_refr_rdaddr_seq", r_addr_err, 0);
        check("rst_refr_done_count", r_ndone, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
